// File: rtl/workload_injector.sv
// Host-side traffic source/sink for the chiplet token protocol: issues {id, size}
// tokens on every issue lane, consumes {id, macs} results in order and times the run.
module workload_injector #(
    parameter int id_width_p        = 8,
    parameter int size_width_p      = 8,
    parameter int num_out_p         = 1,
    parameter int num_in_p          = 1,
    parameter int num_tokens_p      = 16,
    parameter int max_outstanding_p = 4,
    parameter int token_size_p      = 8,
    parameter int width_p           = id_width_p + size_width_p,
    parameter int cnt_width_p       = $clog2(num_tokens_p + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         start_i,
    output logic [num_out_p-1:0]         v_o,
    output logic [num_out_p*width_p-1:0] data_o,
    input  logic [num_out_p-1:0]         ready_i,
    input  logic [num_in_p-1:0]          v_i,
    input  logic [num_in_p*width_p-1:0]  data_i,
    output logic [num_in_p-1:0]          ready_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         error_o,
    output logic [31:0]                  cycles_o,
    output logic [1:0]                   state_o
);

    localparam int out_width_lp = $clog2(max_outstanding_p + 1);
    localparam logic [out_width_lp-1:0] max_out_lp   = out_width_lp'(max_outstanding_p);
    localparam logic [out_width_lp-1:0] out_one_lp   = out_width_lp'(1);
    localparam logic [cnt_width_p-1:0]  num_tok_lp   = cnt_width_p'(num_tokens_p);
    localparam logic [cnt_width_p-1:0]  last_tok_lp  = cnt_width_p'(num_tokens_p - 1);
    localparam logic [cnt_width_p-1:0]  cnt_one_lp   = cnt_width_p'(1);
    localparam logic [id_width_p-1:0]   id_one_lp    = id_width_p'(1);
    localparam logic [size_width_p-1:0] size_lp      = size_width_p'(token_size_p);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_e;

    state_e                  state_r, state_n;
    logic [num_out_p-1:0]    sent_r;
    logic [cnt_width_p-1:0]  issued_r, completed_r, completed_n;
    logic [out_width_lp-1:0] outstanding_r;
    logic [id_width_p-1:0]   issue_id_r, expected_id_r;
    logic [31:0]             cycles_r;
    logic                    error_r;

    logic                    start_run, issue_en, full_send, consume, mismatch;
    logic [num_out_p-1:0]    xfer;
    logic                    unused_macs;

    // Handshake: a lane transfers on the cycle its valid and ready are both high.
    // Issue lanes drop valid once they have accepted the current token; result
    // lanes are consumed only together, on the cycle every result valid is high.
    assign start_run = start_i & ((state_r == IDLE) | (state_r == DONE));
    assign issue_en  = (state_r == ISSUE) & (outstanding_r < max_out_lp);
    assign v_o       = {num_out_p{issue_en}} & ~sent_r;
    assign xfer      = v_o & ready_i;
    assign full_send = issue_en & (&(sent_r | xfer));
    assign consume   = ((state_r == ISSUE) | (state_r == DRAIN)) & (&v_i);
    assign ready_o   = {num_in_p{consume}};

    assign completed_n = consume ? completed_r + cnt_one_lp : completed_r;
    assign unused_macs = ^data_i;

    always_comb begin
        data_o = '0;
        for (int k = 0; k < num_out_p; k++) begin
            data_o[k*width_p +: width_p] = {issue_id_r, size_lp};
        end
    end

    always_comb begin
        mismatch = 1'b0;
        for (int j = 0; j < num_in_p; j++) begin
            if (data_i[j*width_p+size_width_p +: id_width_p] != expected_id_r) begin
                mismatch = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE, DONE: if (start_i) state_n = ISSUE;
            ISSUE:      if (full_send && issued_r == last_tok_lp) state_n = DRAIN;
            DRAIN:      if (completed_n >= num_tok_lp) state_n = DONE;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sent_r        <= '0;
            issued_r      <= '0;
            completed_r   <= '0;
            outstanding_r <= '0;
            issue_id_r    <= '0;
            expected_id_r <= '0;
            cycles_r      <= '0;
            error_r       <= 1'b0;
        end else if (start_run) begin
            sent_r        <= '0;
            issued_r      <= '0;
            completed_r   <= '0;
            outstanding_r <= '0;
            issue_id_r    <= '0;
            expected_id_r <= '0;
            cycles_r      <= '0;
            error_r       <= 1'b0;
        end else begin
            if (busy_o && cycles_r != '1) begin
                cycles_r <= cycles_r + 32'd1;
            end
            if (full_send) begin
                sent_r     <= '0;
                issued_r   <= issued_r + cnt_one_lp;
                issue_id_r <= issue_id_r + id_one_lp;
            end else begin
                sent_r <= sent_r | xfer;
            end
            if (consume) begin
                completed_r   <= completed_n;
                expected_id_r <= expected_id_r + id_one_lp;
                if (mismatch) error_r <= 1'b1;
            end
            // A send and a consume in the same cycle cancel out.
            case ({full_send, consume})
                2'b10:   outstanding_r <= outstanding_r + out_one_lp;
                2'b01:   if (outstanding_r != '0) outstanding_r <= outstanding_r - out_one_lp;
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    assign busy_o   = (state_r == ISSUE) | (state_r == DRAIN);
    assign done_o   = (state_r == DONE);
    assign error_o  = error_r;
    assign cycles_o = cycles_r;
    assign state_o  = state_r;

endmodule

// File: tb/tb_workload_injector.sv
// Directed bench for workload_injector: two issue lanes, two result lanes,
// 2-bit ids, six tokens per run, at most four outstanding.
module tb_workload_injector;

    localparam int IDW = 2;
    localparam int SZW = 4;
    localparam int W   = IDW + SZW;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          start_i;
    logic [1:0]    v_o;
    logic [2*W-1:0] data_o;
    logic [1:0]    ready_i;
    logic [1:0]    v_i;
    logic [2*W-1:0] data_i;
    logic [1:0]    ready_o;
    logic          busy_o, done_o, error_o;
    logic [31:0]   cycles_o;
    logic [1:0]    state_o;

    int vec_count = 0;
    int err_count = 0;

    always #5 clk = ~clk;

    workload_injector #(
        .id_width_p(IDW), .size_width_p(SZW), .num_out_p(2), .num_in_p(2),
        .num_tokens_p(6), .max_outstanding_p(4), .token_size_p(8)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
        .v_o(v_o), .data_o(data_o), .ready_i(ready_i),
        .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .cycles_o(cycles_o), .state_o(state_o)
    );

    // Issue token {id, 8} broadcast on both lanes.
    function automatic logic [2*W-1:0] tok2(input int id);
        logic [W-1:0] t;
        t = {IDW'(id), 4'd8};
        return {t, t};
    endfunction

    // Result tokens with arbitrary macs fields.
    function automatic logic [2*W-1:0] res2(input int id0, input int id1);
        return {IDW'(id1), 4'h3, IDW'(id0), 4'h5};
    endfunction

    task automatic drive(input logic st, input logic [1:0] rdy,
                         input logic [1:0] vin, input logic [2*W-1:0] din);
        @(negedge clk);
        start_i = st;
        ready_i = rdy;
        v_i     = vin;
        data_i  = din;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 2'b11, 2'b11, res2(0, 0));
        vec_count++; if (v_o !== 2'b00) begin err_count++; $display("FAIL reset_v_o: got %b exp 00", v_o); end
        vec_count++; if (ready_o !== 2'b00) begin err_count++; $display("FAIL reset_ready_o: got %b exp 00", ready_o); end
        vec_count++; if (busy_o !== 1'b0 || done_o !== 1'b0 || error_o !== 1'b0) begin
            err_count++; $display("FAIL reset_flags: busy=%b done=%b error=%b exp 0 0 0", busy_o, done_o, error_o); end
        vec_count++; if (cycles_o !== 32'd0) begin err_count++; $display("FAIL reset_cycles: got %0d exp 0", cycles_o); end
        vec_count++; if (state_o !== 2'd0) begin err_count++; $display("FAIL reset_state: got %0d exp 0", state_o); end
        @(negedge clk);
        reset_i = 1'b0;
        drive(1'b0, 2'b00, 2'b11, res2(0, 0));
        vec_count++; if (ready_o !== 2'b00) begin err_count++; $display("FAIL idle_ready_o: got %b exp 00", ready_o); end
    endtask

    task automatic test_skewed_lanes();
        drive(1'b1, 2'b01, 2'b00, '0);
        vec_count++; if (v_o !== 2'b00) begin err_count++; $display("FAIL skew_start_v: got %b exp 00", v_o); end
        drive(1'b0, 2'b01, 2'b00, '0);
        vec_count++; if (v_o !== 2'b11) begin err_count++; $display("FAIL skew_c0_v: got %b exp 11", v_o); end
        vec_count++; if (data_o !== tok2(0)) begin err_count++; $display("FAIL skew_c0_data: got %h exp %h", data_o, tok2(0)); end
        vec_count++; if (state_o !== 2'd1 || busy_o !== 1'b1) begin err_count++; $display("FAIL skew_c0_state: got %0d/%b exp 1/1", state_o, busy_o); end
        for (int c = 1; c <= 2; c++) begin
            drive(1'b0, 2'b00, 2'b00, '0);
            vec_count++; if (v_o !== 2'b10) begin err_count++; $display("FAIL skew_c%0d_v: got %b exp 10", c, v_o); end
        end
        drive(1'b0, 2'b10, 2'b00, '0);
        vec_count++; if (v_o !== 2'b10) begin err_count++; $display("FAIL skew_c3_v: got %b exp 10", v_o); end
        vec_count++; if (data_o !== tok2(0)) begin err_count++; $display("FAIL skew_c3_data: got %h exp %h", data_o, tok2(0)); end
        drive(1'b0, 2'b11, 2'b00, '0);
        vec_count++; if (v_o !== 2'b11) begin err_count++; $display("FAIL skew_c4_v: got %b exp 11", v_o); end
        vec_count++; if (data_o !== tok2(1)) begin err_count++; $display("FAIL skew_c4_data: got %h exp %h", data_o, tok2(1)); end
    endtask

    task automatic test_outstanding_limit();
        for (int id = 2; id <= 3; id++) begin
            drive(1'b0, 2'b11, 2'b00, '0);
            vec_count++; if (v_o !== 2'b11 || data_o !== tok2(id)) begin
                err_count++; $display("FAIL limit_issue%0d: got v=%b d=%h exp v=11 d=%h", id, v_o, data_o, tok2(id)); end
        end
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 2'b11, 2'b00, '0);
            vec_count++; if (v_o !== 2'b00 || state_o !== 2'd1) begin
                err_count++; $display("FAIL limit_hold%0d: got v=%b st=%0d exp v=00 st=1", c, v_o, state_o); end
        end
        drive(1'b0, 2'b11, 2'b11, res2(0, 0));
        vec_count++; if (ready_o !== 2'b11) begin err_count++; $display("FAIL limit_consume_ready: got %b exp 11", ready_o); end
        vec_count++; if (v_o !== 2'b00) begin err_count++; $display("FAIL limit_same_cycle_v: got %b exp 00", v_o); end
        drive(1'b0, 2'b11, 2'b00, '0);
        vec_count++; if (v_o !== 2'b11 || data_o !== tok2(0)) begin
            err_count++; $display("FAIL limit_one_more: got v=%b d=%h exp v=11 d=%h", v_o, data_o, tok2(0)); end
        vec_count++; if (ready_o !== 2'b00) begin err_count++; $display("FAIL limit_no_result_ready: got %b exp 00", ready_o); end
    endtask

    task automatic test_id_mismatch();
        drive(1'b0, 2'b11, 2'b11, res2(1, 2));
        vec_count++; if (v_o !== 2'b00) begin err_count++; $display("FAIL mism_v_full: got %b exp 00", v_o); end
        vec_count++; if (ready_o !== 2'b11 || error_o !== 1'b0) begin
            err_count++; $display("FAIL mism_pre: got ready=%b err=%b exp 11 0", ready_o, error_o); end
        drive(1'b0, 2'b11, 2'b00, '0);
        vec_count++; if (error_o !== 1'b1) begin err_count++; $display("FAIL mism_error_set: got %b exp 1", error_o); end
        vec_count++; if (v_o !== 2'b11 || data_o !== tok2(1)) begin
            err_count++; $display("FAIL mism_last_issue: got v=%b d=%h exp v=11 d=%h", v_o, data_o, tok2(1)); end
        drive(1'b0, 2'b11, 2'b11, res2(2, 2));
        vec_count++; if (state_o !== 2'd2 || v_o !== 2'b00) begin
            err_count++; $display("FAIL mism_drain: got st=%0d v=%b exp st=2 v=00", state_o, v_o); end
        drive(1'b0, 2'b11, 2'b11, res2(3, 3));
        drive(1'b0, 2'b11, 2'b11, res2(0, 0));
        drive(1'b0, 2'b11, 2'b11, res2(1, 1));
        vec_count++; if (state_o !== 2'd2 || ready_o !== 2'b11) begin
            err_count++; $display("FAIL mism_last_result: got st=%0d ready=%b exp st=2 ready=11", state_o, ready_o); end
        drive(1'b0, 2'b00, 2'b11, res2(2, 2));
        vec_count++; if (done_o !== 1'b1 || busy_o !== 1'b0 || state_o !== 2'd3) begin
            err_count++; $display("FAIL mism_done: got done=%b busy=%b st=%0d exp 1 0 3", done_o, busy_o, state_o); end
        vec_count++; if (error_o !== 1'b1) begin err_count++; $display("FAIL mism_sticky: got %b exp 1", error_o); end
        vec_count++; if (cycles_o !== 32'd18) begin err_count++; $display("FAIL mism_cycles: got %0d exp 18", cycles_o); end
        vec_count++; if (ready_o !== 2'b00) begin err_count++; $display("FAIL done_ready_o: got %b exp 00", ready_o); end
        drive(1'b0, 2'b00, 2'b00, '0);
        drive(1'b0, 2'b00, 2'b00, '0);
        vec_count++; if (cycles_o !== 32'd18 || done_o !== 1'b1) begin
            err_count++; $display("FAIL done_frozen: got cycles=%0d done=%b exp 18 1", cycles_o, done_o); end
    endtask

    task automatic test_id_wrap();
        drive(1'b1, 2'b11, 2'b00, '0);
        vec_count++; if (state_o !== 2'd3) begin err_count++; $display("FAIL wrap_start_state: got %0d exp 3", state_o); end
        for (int id = 0; id <= 3; id++) begin
            drive(1'b0, 2'b11, 2'b00, '0);
            vec_count++; if (v_o !== 2'b11 || data_o !== tok2(id)) begin
                err_count++; $display("FAIL wrap_issue%0d: got v=%b d=%h exp v=11 d=%h", id, v_o, data_o, tok2(id)); end
            if (id == 0) begin
                vec_count++; if (error_o !== 1'b0 || cycles_o !== 32'd0) begin
                    err_count++; $display("FAIL wrap_cleared: got err=%b cycles=%0d exp 0 0", error_o, cycles_o); end
            end
        end
        drive(1'b0, 2'b11, 2'b11, res2(0, 0));
        vec_count++; if (v_o !== 2'b00 || ready_o !== 2'b11) begin
            err_count++; $display("FAIL wrap_c4: got v=%b ready=%b exp 00 11", v_o, ready_o); end
        drive(1'b0, 2'b11, 2'b11, res2(1, 1));
        vec_count++; if (v_o !== 2'b11 || data_o !== tok2(0) || ready_o !== 2'b11) begin
            err_count++; $display("FAIL wrap_c5: got v=%b d=%h ready=%b exp 11 %h 11", v_o, data_o, ready_o, tok2(0)); end
        drive(1'b0, 2'b11, 2'b11, res2(2, 2));
        vec_count++; if (v_o !== 2'b11 || data_o !== tok2(1)) begin
            err_count++; $display("FAIL wrap_c6: got v=%b d=%h exp 11 %h", v_o, data_o, tok2(1)); end
        drive(1'b0, 2'b11, 2'b11, res2(3, 3));
        vec_count++; if (state_o !== 2'd2 || v_o !== 2'b00) begin
            err_count++; $display("FAIL wrap_drain: got st=%0d v=%b exp 2 00", state_o, v_o); end
        drive(1'b0, 2'b11, 2'b11, res2(0, 0));
        drive(1'b0, 2'b11, 2'b11, res2(1, 1));
        drive(1'b0, 2'b00, 2'b00, '0);
        vec_count++; if (done_o !== 1'b1 || error_o !== 1'b0) begin
            err_count++; $display("FAIL wrap_done: got done=%b err=%b exp 1 0", done_o, error_o); end
        vec_count++; if (cycles_o !== 32'd10) begin err_count++; $display("FAIL wrap_cycles: got %0d exp 10", cycles_o); end
    endtask

    task automatic test_reset_mid_run();
        drive(1'b1, 2'b11, 2'b00, '0);
        drive(1'b0, 2'b11, 2'b00, '0);
        drive(1'b0, 2'b11, 2'b00, '0);
        drive(1'b0, 2'b11, 2'b00, '0);
        vec_count++; if (v_o !== 2'b11 || data_o !== tok2(2)) begin
            err_count++; $display("FAIL rst_pre: got v=%b d=%h exp 11 %h", v_o, data_o, tok2(2)); end
        #2;
        reset_i = 1'b1;
        #1;
        vec_count++; if (v_o !== 2'b00) begin err_count++; $display("FAIL rst_async_v: got %b exp 00", v_o); end
        vec_count++; if (state_o !== 2'd0 || busy_o !== 1'b0 || cycles_o !== 32'd0) begin
            err_count++; $display("FAIL rst_async_state: got st=%0d busy=%b cycles=%0d exp 0 0 0", state_o, busy_o, cycles_o); end
        @(negedge clk);
        reset_i = 1'b0;
        drive(1'b1, 2'b11, 2'b00, '0);
        drive(1'b0, 2'b11, 2'b00, '0);
        vec_count++; if (v_o !== 2'b11 || data_o !== tok2(0) || state_o !== 2'd1) begin
            err_count++; $display("FAIL rst_restart: got v=%b d=%h st=%0d exp 11 %h 1", v_o, data_o, state_o, tok2(0)); end
    endtask

    initial begin
        reset_i = 1'b1;
        start_i = 1'b0;
        ready_i = 2'b00;
        v_i     = 2'b00;
        data_i  = '0;
        test_reset();
        test_skewed_lanes();
        test_outstanding_limit();
        test_id_mismatch();
        test_id_wrap();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
